s2mm_writer: RTL and testbench



---
 rtl/s2mm_writer.sv | 165 ++++++++++++++++
 tb/tb_s2mm_writer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s2mm_writer.sv
// rtl/s2mm_writer.sv - AXI-Stream to AXI4 burst writer with two ping-pong slots; optional macro S2MM_OVERLAP_EN
module s2mm_writer #(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_LEN     = 16
) (
  input  logic                       SYS_aclk,
  input  logic                       SYS_reset,
  input  logic [DATA_WIDTH-1:0]      S_AXIS_tdata,
  input  logic                       S_AXIS_tvalid,
  output logic                       S_AXIS_tready,
  input  logic [MM_ADDR_WIDTH-1:0]   SM_write_buffer,
  output logic                       SM_reading,
  output logic                       SM_writing,
  output logic [MM_ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic [7:0]                 M_AXI_awlen,
  output logic [2:0]                 M_AXI_awsize,
  output logic [1:0]                 M_AXI_awburst,
  output logic                       M_AXI_awvalid,
  input  logic                       M_AXI_awready,
  output logic [DATA_WIDTH-1:0]      M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0]    M_AXI_wstrb,
  output logic                       M_AXI_wlast,
  output logic                       M_AXI_wvalid,
  input  logic                       M_AXI_wready,
  input  logic [1:0]                 M_AXI_bresp,
  input  logic                       M_AXI_bvalid,
  output logic                       M_AXI_bready,
  output logic                       ERR_bresp
);
  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]    mem [2*BURST_LEN];
  logic [MM_ADDR_WIDTH-1:0] slot_addr [2];
  logic [1:0]               full_q;
  logic                     fill_sel, drain_sel;
  logic [CW-1:0]            fill_cnt, drain_cnt;
  logic                     err_q;
  logic                     fill_hs, fill_last, w_hs, b_hs, slot_ready;

  assign M_AXI_awlen   = 8'(BURST_LEN - 1);
  assign M_AXI_awsize  = 3'($clog2(DATA_WIDTH / 8));
  assign M_AXI_awburst = 2'b01;
  assign M_AXI_wstrb   = '1;

  assign S_AXIS_tready = ~full_q[fill_sel];
  assign fill_hs       = S_AXIS_tvalid & S_AXIS_tready;
  assign fill_last     = fill_hs & (fill_cnt == LAST_BEAT);
  assign w_hs          = M_AXI_wvalid & M_AXI_wready;
  assign b_hs          = M_AXI_bready & M_AXI_bvalid;
  assign SM_reading    = fill_hs;
  assign SM_writing    = w_hs;
  assign ERR_bresp     = err_q;

  // The last fill beat into the drain slot is forwarded so AW starts the cycle after it.
  assign slot_ready    = full_q[drain_sel] | (fill_last & (fill_sel == drain_sel));

  assign M_AXI_awaddr  = slot_addr[drain_sel];
  assign M_AXI_wdata   = M_AXI_wvalid ? mem[{drain_sel, drain_cnt}] : '0;
  assign M_AXI_wlast   = M_AXI_wvalid & (drain_cnt == LAST_BEAT);

  // Slot storage write port; contents need no reset since full flags gate every read.
  always_ff @(posedge SYS_aclk) begin
    if (fill_hs) mem[{fill_sel, fill_cnt}] <= S_AXIS_tdata;
  end

  // Fill side: beat counter, slot pointer and start address capture.
  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) begin
      fill_cnt     <= '0;
      fill_sel     <= 1'b0;
      slot_addr[0] <= '0;
      slot_addr[1] <= '0;
    end else if (fill_hs) begin
      fill_cnt <= fill_cnt + CW'(1);
      if (fill_cnt == '0) slot_addr[fill_sel] <= SM_write_buffer;
      if (fill_cnt == LAST_BEAT) fill_sel <= ~fill_sel;
    end
  end

  // Slot occupancy: set by the fill side, cleared by the write response.
  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) begin
      full_q <= 2'b00;
    end else begin
      if (fill_last) full_q[fill_sel] <= 1'b1;
      if (b_hs) full_q[drain_sel] <= 1'b0;
    end
  end

  // Drain side: beat counter, slot pointer and sticky response error.
  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) begin
      drain_cnt <= '0;
      drain_sel <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (w_hs) drain_cnt <= drain_cnt + CW'(1);
      if (b_hs) begin
        drain_sel <= ~drain_sel;
        if (M_AXI_bresp != 2'b00) err_q <= 1'b1;
      end
    end
  end

`ifdef S2MM_OVERLAP_EN
  logic aw_done_q, w_done_q;

  // Remember which of the AW and W phases already finished during ADDR.
  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset || state_q != ADDR) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (M_AXI_awvalid && M_AXI_awready) aw_done_q <= 1'b1;
      if (w_hs && M_AXI_wlast) w_done_q <= 1'b1;
    end
  end
`endif

  // Drain FSM state register.
  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Drain FSM next state and AXI valid/ready outputs.
  always_comb begin
    state_d       = state_q;
    M_AXI_awvalid = 1'b0;
    M_AXI_wvalid  = 1'b0;
    M_AXI_bready  = 1'b0;
    case (state_q)
      IDLE: if (slot_ready) state_d = ADDR;
`ifdef S2MM_OVERLAP_EN
      ADDR: begin
        M_AXI_awvalid = ~aw_done_q;
        M_AXI_wvalid  = ~w_done_q;
        if ((aw_done_q | M_AXI_awready) &&
            (w_done_q | (M_AXI_wready & (drain_cnt == LAST_BEAT))))
          state_d = RESP;
      end
`else
      ADDR: begin
        M_AXI_awvalid = 1'b1;
        if (M_AXI_awready) state_d = DATA;
      end
`endif
      DATA: begin
        M_AXI_wvalid = 1'b1;
        if (M_AXI_wready && drain_cnt == LAST_BEAT) state_d = RESP;
      end
      RESP: begin
        M_AXI_bready = 1'b1;
        if (M_AXI_bvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_s2mm_writer.sv
// tb/tb_s2mm_writer.sv - directed self-checking bench for s2mm_writer
module tb_s2mm_writer;
  logic        SYS_aclk = 1'b0;
  logic        SYS_reset;
  logic [31:0] S_AXIS_tdata;
  logic        S_AXIS_tvalid;
  logic        S_AXIS_tready;
  logic [31:0] SM_write_buffer;
  logic        SM_reading, SM_writing;
  logic [31:0] M_AXI_awaddr;
  logic [7:0]  M_AXI_awlen;
  logic [2:0]  M_AXI_awsize;
  logic [1:0]  M_AXI_awburst;
  logic        M_AXI_awvalid, M_AXI_awready;
  logic [31:0] M_AXI_wdata;
  logic [3:0]  M_AXI_wstrb;
  logic        M_AXI_wlast, M_AXI_wvalid, M_AXI_wready;
  logic [1:0]  M_AXI_bresp;
  logic        M_AXI_bvalid, M_AXI_bready;
  logic        ERR_bresp;

  s2mm_writer #(.MM_ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(16)) dut (
    .SYS_aclk(SYS_aclk), .SYS_reset(SYS_reset),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
    .SM_write_buffer(SM_write_buffer), .SM_reading(SM_reading), .SM_writing(SM_writing),
    .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awlen(M_AXI_awlen), .M_AXI_awsize(M_AXI_awsize),
    .M_AXI_awburst(M_AXI_awburst), .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready),
    .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb), .M_AXI_wlast(M_AXI_wlast),
    .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready),
    .M_AXI_bresp(M_AXI_bresp), .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bready(M_AXI_bready),
    .ERR_bresp(ERR_bresp)
  );

  always #5 SYS_aclk = ~SYS_aclk;

  int checks = 0;
  int errors = 0;

  // slave behaviour knobs
  int aw_delay = 0;
  int b_delay = 0;
  int err_burst = -1;
  bit w_toggle = 0;

  // observation logs
  int cyc = 0;
  int aw_start_q[$], aw_cyc_q[$], w_cyc_q[$], b_cyc_q[$], br_rise_q[$], rd_cyc_q[$];
  logic [31:0] aw_addr_q[$], w_data_q[$];
  logic w_last_q[$];
  int rd_cnt, wr_cnt, bad_rd, bad_wr, unstable;

  // slave/monitor state
  logic awv_prev = 0, br_prev = 0, w_stall = 0;
  logic [31:0] w_stall_data;
  bit aw_hs_f, awv_f, wlast_hs_f, b_hs_f, rst_f;
  int aw_wait = 0, b_pend = 0, b_timer = 0, b_num = 0;

  task automatic clear_logs();
    aw_start_q.delete(); aw_cyc_q.delete(); w_cyc_q.delete(); b_cyc_q.delete();
    br_rise_q.delete(); rd_cyc_q.delete(); aw_addr_q.delete(); w_data_q.delete(); w_last_q.delete();
    rd_cnt = 0; wr_cnt = 0; bad_rd = 0; bad_wr = 0; unstable = 0; b_num = 0;
  endtask

  // Monitor samples at negedge; the AXI slave updates its outputs 1 time unit after posedge.
  initial begin
    M_AXI_awready = 1'b1; M_AXI_wready = 1'b1; M_AXI_bvalid = 1'b0; M_AXI_bresp = 2'b00;
    clear_logs();
    forever begin
      @(negedge SYS_aclk);
      cyc++;
      rst_f = SYS_reset;
      aw_hs_f = 0; awv_f = 0; wlast_hs_f = 0; b_hs_f = 0;
      if (!SYS_reset) begin
        awv_f = M_AXI_awvalid;
        if (M_AXI_awvalid && !awv_prev) aw_start_q.push_back(cyc);
        if (M_AXI_awvalid && M_AXI_awready) begin
          aw_hs_f = 1; aw_cyc_q.push_back(cyc); aw_addr_q.push_back(M_AXI_awaddr);
        end
        if (w_stall && (!M_AXI_wvalid || M_AXI_wdata !== w_stall_data)) unstable++;
        if (M_AXI_wvalid && M_AXI_wready) begin
          w_cyc_q.push_back(cyc); w_data_q.push_back(M_AXI_wdata); w_last_q.push_back(M_AXI_wlast);
          wlast_hs_f = M_AXI_wlast;
        end
        if (M_AXI_bready && !br_prev) br_rise_q.push_back(cyc);
        if (M_AXI_bready && M_AXI_bvalid) begin b_hs_f = 1; b_cyc_q.push_back(cyc); end
        if (S_AXIS_tvalid && S_AXIS_tready) rd_cyc_q.push_back(cyc);
        if (SM_reading) rd_cnt++;
        if (SM_writing) wr_cnt++;
        if (SM_reading !== (S_AXIS_tvalid & S_AXIS_tready)) bad_rd++;
        if (SM_writing !== (M_AXI_wvalid & M_AXI_wready)) bad_wr++;
        awv_prev = M_AXI_awvalid; br_prev = M_AXI_bready;
        w_stall = M_AXI_wvalid & ~M_AXI_wready; w_stall_data = M_AXI_wdata;
      end else begin
        awv_prev = 0; br_prev = 0; w_stall = 0;
      end
      @(posedge SYS_aclk); #1;
      if (rst_f) begin
        aw_wait = 0; b_pend = 0; b_timer = 0; M_AXI_bvalid = 1'b0; M_AXI_wready = 1'b1;
        M_AXI_awready = (aw_delay == 0);
      end else begin
        if (aw_hs_f) aw_wait = 0; else if (awv_f) aw_wait++;
        M_AXI_awready = (aw_wait >= aw_delay);
        M_AXI_wready = w_toggle ? ~M_AXI_wready : 1'b1;
        if (b_hs_f) begin M_AXI_bvalid = 1'b0; b_pend--; b_num++; b_timer = 0; end
        if (wlast_hs_f) b_pend++;
        if (b_pend > 0 && !M_AXI_bvalid) begin
          if (b_timer >= b_delay) begin
            M_AXI_bvalid = 1'b1;
            M_AXI_bresp = (b_num == err_burst) ? 2'b10 : 2'b00;
          end else b_timer++;
        end
      end
    end
  end

  // Drives n beats starting at posedge+1; beat i carries first+i and buffer address base+4*i.
  task automatic send_beats(input logic [31:0] first, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      int waits = 0;
      S_AXIS_tdata = first + i; SM_write_buffer = base + 32'(4 * i); S_AXIS_tvalid = 1'b1;
      @(negedge SYS_aclk);
      while (!S_AXIS_tready && waits < 2000) begin waits++; @(negedge SYS_aclk); end
      if (!S_AXIS_tready) begin
        checks++; errors++;
        $display("FAIL send_timeout: beat %0d not accepted, required acceptance within 2000 cycles", i);
        @(posedge SYS_aclk); #1;
        S_AXIS_tvalid = 1'b0;
        return;
      end
      @(posedge SYS_aclk); #1;
    end
    S_AXIS_tvalid = 1'b0;
  endtask

  task automatic wait_bursts(input int n);
    int t = 0;
    while (b_cyc_q.size() < n && t < 3000) begin @(posedge SYS_aclk); #1; t++; end
    if (b_cyc_q.size() < n) begin
      checks++; errors++;
      $display("FAIL burst_timeout: got %0d B handshakes, required %0d", b_cyc_q.size(), n);
    end
    repeat (3) @(posedge SYS_aclk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] flags;
    flags = {S_AXIS_tready, M_AXI_awvalid, M_AXI_wvalid, M_AXI_wlast, M_AXI_bready, SM_reading, SM_writing, ERR_bresp};
    checks++; if (flags !== 8'b1000_0000) begin errors++; $display("FAIL reset_flags: got %b required 10000000", flags); end
    checks++; if (M_AXI_awaddr !== 32'h0) begin errors++; $display("FAIL reset_awaddr: got %h required 0", M_AXI_awaddr); end
    checks++; if (M_AXI_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h required 0", M_AXI_wdata); end
    checks++; if ({M_AXI_awlen, M_AXI_awsize, M_AXI_awburst, M_AXI_wstrb} !== {8'd15, 3'd2, 2'b01, 4'hf}) begin
      errors++; $display("FAIL const_fields: got len %0d size %0d burst %b strb %h required 15 2 01 f",
                         M_AXI_awlen, M_AXI_awsize, M_AXI_awburst, M_AXI_wstrb);
    end
    SYS_reset = 1'b0;
    @(posedge SYS_aclk); #1;
    checks++; if (S_AXIS_tready !== 1'b1) begin errors++; $display("FAIL tready_after_reset: got %b required 1", S_AXIS_tready); end
  endtask

  task automatic test_single_burst();
    clear_logs();
    send_beats(32'h1, 16, 32'h1000_0000);
    wait_bursts(1);
    checks++; if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h1000_0000) begin
      errors++; $display("FAIL single_aw: got %0d bursts addr %h required 1 burst addr 10000000", aw_addr_q.size(), aw_addr_q.size() ? aw_addr_q[0] : 32'hx);
    end
    checks++; if (w_data_q.size() != 16) begin errors++; $display("FAIL single_wcount: got %0d required 16", w_data_q.size()); end
    else for (int i = 0; i < 16; i++) begin
      checks++; if (w_data_q[i] !== 32'(i + 1) || w_last_q[i] !== (i == 15)) begin
        errors++; $display("FAIL single_beat%0d: got data %h last %b required data %h last %b", i, w_data_q[i], w_last_q[i], i + 1, i == 15);
      end
    end
    checks++; if (rd_cnt != 16 || wr_cnt != 16) begin errors++; $display("FAIL single_pulses: got rd %0d wr %0d required 16 16", rd_cnt, wr_cnt); end
    checks++; if (bad_rd != 0 || bad_wr != 0) begin errors++; $display("FAIL single_pulse_shape: got bad_rd %0d bad_wr %0d required 0 0", bad_rd, bad_wr); end
    if (rd_cyc_q.size() == 16 && aw_start_q.size() == 1 && aw_cyc_q.size() == 1 && w_cyc_q.size() == 16 && br_rise_q.size() >= 1) begin
      checks++; if (aw_start_q[0] != rd_cyc_q[15] + 1) begin errors++; $display("FAIL aw_latency: got cycle %0d required %0d", aw_start_q[0], rd_cyc_q[15] + 1); end
`ifdef S2MM_OVERLAP_EN
      checks++; if (w_cyc_q[0] != aw_start_q[0]) begin errors++; $display("FAIL w_first: got cycle %0d required %0d", w_cyc_q[0], aw_start_q[0]); end
`else
      checks++; if (w_cyc_q[0] != aw_cyc_q[0] + 1) begin errors++; $display("FAIL w_first: got cycle %0d required %0d", w_cyc_q[0], aw_cyc_q[0] + 1); end
`endif
      checks++; if (w_cyc_q[15] != w_cyc_q[0] + 15) begin errors++; $display("FAIL w_back_to_back: got span %0d required 15", w_cyc_q[15] - w_cyc_q[0]); end
      checks++; if (br_rise_q[0] != w_cyc_q[15] + 1) begin errors++; $display("FAIL bready_latency: got cycle %0d required %0d", br_rise_q[0], w_cyc_q[15] + 1); end
    end else begin
      checks++; errors++; $display("FAIL single_timing_logs: got rd %0d aw %0d w %0d required 16 1 16", rd_cyc_q.size(), aw_cyc_q.size(), w_cyc_q.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    b_delay = 40;
    send_beats(32'h100, 64, 32'h2000_0000);
    wait_bursts(4);
    b_delay = 0;
    checks++; if (aw_addr_q.size() != 4) begin errors++; $display("FAIL b2b_bursts: got %0d required 4", aw_addr_q.size()); end
    else for (int k = 0; k < 4; k++) begin
      checks++; if (aw_addr_q[k] !== 32'h2000_0000 + 32'(64 * k)) begin
        errors++; $display("FAIL b2b_awaddr%0d: got %h required %h", k, aw_addr_q[k], 32'h2000_0000 + 32'(64 * k));
      end
    end
    checks++; if (w_data_q.size() != 64) begin errors++; $display("FAIL b2b_wcount: got %0d required 64", w_data_q.size()); end
    else for (int i = 0; i < 64; i++) begin
      checks++; if (w_data_q[i] !== 32'h100 + 32'(i) || w_last_q[i] !== (i % 16 == 15)) begin
        errors++; $display("FAIL b2b_beat%0d: got data %h last %b required %h %b", i, w_data_q[i], w_last_q[i], 32'h100 + 32'(i), i % 16 == 15);
      end
    end
    if (rd_cyc_q.size() == 64 && b_cyc_q.size() >= 1) begin
      checks++; if (rd_cyc_q[31] != rd_cyc_q[0] + 31) begin errors++; $display("FAIL b2b_first32_span: got %0d required 31", rd_cyc_q[31] - rd_cyc_q[0]); end
      checks++; if (rd_cyc_q[32] <= rd_cyc_q[31] + 1) begin errors++; $display("FAIL b2b_stall: got gap %0d required above 1", rd_cyc_q[32] - rd_cyc_q[31]); end
      checks++; if (rd_cyc_q[32] != b_cyc_q[0] + 1) begin errors++; $display("FAIL b2b_resume: got cycle %0d required %0d", rd_cyc_q[32], b_cyc_q[0] + 1); end
    end else begin
      checks++; errors++; $display("FAIL b2b_logs: got %0d beats %0d B required 64 4", rd_cyc_q.size(), b_cyc_q.size());
    end
    checks++; if (rd_cnt != 64 || wr_cnt != 64) begin errors++; $display("FAIL b2b_pulses: got rd %0d wr %0d required 64 64", rd_cnt, wr_cnt); end
    checks++; if (ERR_bresp !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b required 0", ERR_bresp); end
  endtask

  task automatic test_wready_toggle();
    clear_logs();
    w_toggle = 1;
    send_beats(32'h400, 16, 32'h0000_4000);
    wait_bursts(1);
    w_toggle = 0;
    checks++; if (unstable != 0) begin errors++; $display("FAIL toggle_stable: got %0d unstable cycles required 0", unstable); end
    checks++; if (bad_wr != 0) begin errors++; $display("FAIL toggle_writing_shape: got %0d bad cycles required 0", bad_wr); end
    checks++; if (wr_cnt != 16) begin errors++; $display("FAIL toggle_pulses: got %0d required 16", wr_cnt); end
    checks++; if (w_data_q.size() != 16) begin errors++; $display("FAIL toggle_wcount: got %0d required 16", w_data_q.size()); end
    else begin
      checks++; if (w_cyc_q[15] - w_cyc_q[0] != 30) begin errors++; $display("FAIL toggle_span: got %0d required 30", w_cyc_q[15] - w_cyc_q[0]); end
      for (int i = 0; i < 16; i++) begin
        checks++; if (w_data_q[i] !== 32'h400 + 32'(i)) begin errors++; $display("FAIL toggle_beat%0d: got %h required %h", i, w_data_q[i], 32'h400 + 32'(i)); end
      end
    end
  endtask

  task automatic test_bresp_err();
    clear_logs();
    err_burst = 1;
    send_beats(32'h500, 32, 32'h0000_8000);
    wait_bursts(2);
    err_burst = -1;
    checks++; if (ERR_bresp !== 1'b1) begin errors++; $display("FAIL err_set: got %b required 1", ERR_bresp); end
    send_beats(32'h520, 16, 32'h0000_8080);
    wait_bursts(3);
    checks++; if (ERR_bresp !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", ERR_bresp); end
    checks++; if (w_data_q.size() != 48) begin errors++; $display("FAIL err_wcount: got %0d required 48", w_data_q.size()); end
    else for (int i = 0; i < 48; i++) begin
      checks++; if (w_data_q[i] !== 32'h500 + 32'(i)) begin errors++; $display("FAIL err_beat%0d: got %h required %h", i, w_data_q[i], 32'h500 + 32'(i)); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int t = 0;
    clear_logs();
    send_beats(32'h600, 16, 32'h3000_0000);
    #1;
    while (w_data_q.size() < 7 && t < 500) begin @(posedge SYS_aclk); #2; t++; end
    checks++; if (w_data_q.size() != 7) begin errors++; $display("FAIL midrst_reach: got %0d beats required 7", w_data_q.size()); end
    SYS_reset = 1'b1;
    @(posedge SYS_aclk); #1;
    checks++; if ({M_AXI_wvalid, M_AXI_awvalid, M_AXI_bready, S_AXIS_tready, SM_writing, ERR_bresp} !== 6'b000100) begin
      errors++; $display("FAIL midrst_state: got wv %b awv %b br %b trdy %b wr %b err %b required 0 0 0 1 0 0",
                         M_AXI_wvalid, M_AXI_awvalid, M_AXI_bready, S_AXIS_tready, SM_writing, ERR_bresp);
    end
    SYS_reset = 1'b0;
    clear_logs();
    @(posedge SYS_aclk); #1;
    send_beats(32'h700, 16, 32'h3000_1000);
    wait_bursts(1);
    checks++; if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h3000_1000) begin
      errors++; $display("FAIL midrst_aw: got %0d bursts required 1 at 30001000", aw_addr_q.size());
    end
    checks++; if (w_data_q.size() != 16) begin errors++; $display("FAIL midrst_wcount: got %0d required 16", w_data_q.size()); end
    else for (int i = 0; i < 16; i++) begin
      checks++; if (w_data_q[i] !== 32'h700 + 32'(i) || w_last_q[i] !== (i == 15)) begin
        errors++; $display("FAIL midrst_beat%0d: got %h last %b required %h %b", i, w_data_q[i], w_last_q[i], 32'h700 + 32'(i), i == 15);
      end
    end
    checks++; if (rd_cnt != 16 || wr_cnt != 16) begin errors++; $display("FAIL midrst_pulses: got rd %0d wr %0d required 16 16", rd_cnt, wr_cnt); end
  endtask

`ifdef S2MM_OVERLAP_EN
  task automatic test_overlap();
    int delays [2] = '{5, 20};
    for (int d = 0; d < 2; d++) begin
      int aw_c, wl_c;
      clear_logs();
      aw_delay = delays[d];
      send_beats(32'h800 + 32'(32 * d), 16, 32'h4000_0000);
      wait_bursts(1);
      aw_delay = 0;
      if (aw_start_q.size() == 1 && aw_cyc_q.size() == 1 && w_cyc_q.size() == 16 && br_rise_q.size() >= 1) begin
        aw_c = aw_cyc_q[0]; wl_c = w_cyc_q[15];
        checks++; if (w_cyc_q[0] != aw_start_q[0]) begin errors++; $display("FAIL ovl_w_with_aw%0d: got %0d required %0d", d, w_cyc_q[0], aw_start_q[0]); end
        checks++; if (aw_c != aw_start_q[0] + delays[d]) begin errors++; $display("FAIL ovl_aw_delay%0d: got %0d required %0d", d, aw_c, aw_start_q[0] + delays[d]); end
        checks++; if (br_rise_q[0] != ((aw_c > wl_c) ? aw_c : wl_c) + 1) begin
          errors++; $display("FAIL ovl_resp%0d: got %0d required %0d", d, br_rise_q[0], ((aw_c > wl_c) ? aw_c : wl_c) + 1);
        end
      end else begin
        checks++; errors++; $display("FAIL ovl_logs%0d: got aw %0d w %0d required 1 16", d, aw_cyc_q.size(), w_cyc_q.size());
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    SYS_reset = 1'b1; S_AXIS_tvalid = 1'b0; S_AXIS_tdata = '0; SM_write_buffer = '0;
    repeat (3) @(posedge SYS_aclk);
    #1;
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_wready_toggle();
    test_bresp_err();
    test_reset_mid_burst();
`ifdef S2MM_OVERLAP_EN
    test_overlap();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
